// File: rtl/ili_spi_arbiter.sv
// Round-robin arbiter sharing one ILI9341 SPI byte transmitter between a command
// sequencer (req0) and a pixel engine (req1), framing each burst with chip-select.
module ili_spi_arbiter #(
  parameter int unsigned DW       = 8,
  parameter int unsigned CS_SETUP = 1,
  parameter int unsigned CS_GAP   = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,

  input  logic          req0_valid_i,
  input  logic [DW-1:0] req0_data_i,
  input  logic          req0_dc_i,
  input  logic          req0_last_i,
  output logic          req0_ready_o,

  input  logic          req1_valid_i,
  input  logic [DW-1:0] req1_data_i,
  input  logic          req1_dc_i,
  input  logic          req1_last_i,
  output logic          req1_ready_o,

  output logic          tx_valid_o,
  output logic [DW-1:0] tx_data_o,
  output logic          tx_dc_o,
  input  logic          tx_ready_i,
  input  logic          tx_idle_i,

  output logic          cs_o,
  output logic [1:0]    grant_o,
  output logic          busy_o
);

  localparam int unsigned CntMax = (CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] SetupLoad = CntW'(CS_SETUP - 1);
  localparam logic [CntW-1:0] GapLoad   = CntW'(CS_GAP - 1);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StSetup = 3'd1;
  localparam logic [2:0] StXfer  = 3'd2;
  localparam logic [2:0] StDrain = 3'd3;
  localparam logic [2:0] StGap   = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      grant_q, grant_d;
  logic            rr_q, rr_d;  // 0 favours req0, 1 favours req1
  logic            cs_q, cs_d;

  logic            sel_valid;
  logic [DW-1:0]   sel_data;
  logic            sel_dc;
  logic            sel_last;
  logic            in_xfer;
  logic            xfer_fire;
  logic            win1;

  // Mux of the granted requester; only meaningful while a grant is held.
  always_comb begin
    if (grant_q[1]) begin
      sel_valid = req1_valid_i;
      sel_data  = req1_data_i;
      sel_dc    = req1_dc_i;
      sel_last  = req1_last_i;
    end else begin
      sel_valid = req0_valid_i;
      sel_data  = req0_data_i;
      sel_dc    = req0_dc_i;
      sel_last  = req0_last_i;
    end
  end

  assign in_xfer   = (state_q == StXfer);
  assign xfer_fire = in_xfer & sel_valid & tx_ready_i;
  assign win1      = req1_valid_i & (~req0_valid_i | rr_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    cs_d    = cs_q;
    case (state_q)
      StIdle: begin
        if (req0_valid_i | req1_valid_i) begin
          grant_d = win1 ? 2'b10 : 2'b01;
          cs_d    = 1'b0;
          cnt_d   = SetupLoad;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (cnt_q == '0) begin
          state_d = StXfer;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StXfer: begin
        // A stalled requester keeps the bus: no timeout, no re-arbitration.
        if (xfer_fire & sel_last) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (tx_idle_i) begin
          cs_d    = 1'b1;
          grant_d = 2'b00;
          cnt_d   = GapLoad;
          rr_d    = grant_q[0];
          state_d = StGap;
        end
      end
      StGap: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        grant_d = 2'b00;
        cs_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      grant_q <= 2'b00;
      rr_q    <= 1'b0;
      cs_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cs_q    <= cs_d;
    end
  end

  assign tx_valid_o   = in_xfer & sel_valid;
  assign tx_data_o    = in_xfer ? sel_data : '0;
  assign tx_dc_o      = in_xfer ? sel_dc : 1'b1;
  assign req0_ready_o = in_xfer & grant_q[0] & req0_valid_i & tx_ready_i;
  assign req1_ready_o = in_xfer & grant_q[1] & req1_valid_i & tx_ready_i;
  assign cs_o         = cs_q;
  assign grant_o      = grant_q;
  assign busy_o       = (state_q != StIdle);

  grant_onehot_a : assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(grant_q));

  grant_stable_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == StSetup || state_q == StXfer) |=> $stable(grant_q));

  cs_frame_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (cs_q == (state_q == StIdle || state_q == StGap)));

endmodule

// File: tb/tb_ili_spi_arbiter.sv
// Directed bench for ili_spi_arbiter: a burst-level model checked every cycle,
// plus hand-computed expectations on transfer order, framing and timing.
module tb_ili_spi_arbiter;
  localparam int unsigned DW       = 8;
  localparam int unsigned CS_SETUP = 1;
  localparam int unsigned CS_GAP   = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid = 1'b0, req0_dc = 1'b0, req0_last = 1'b0;
  logic [DW-1:0] req0_data = '0;
  logic          req0_ready;
  logic          req1_valid = 1'b0, req1_dc = 1'b0, req1_last = 1'b0;
  logic [DW-1:0] req1_data = '0;
  logic          req1_ready;
  logic          tx_valid, tx_dc;
  logic [DW-1:0] tx_data;
  logic          tx_ready = 1'b1, tx_idle = 1'b1;
  logic          cs, busy;
  logic [1:0]    grant;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic rdy_alt = 1'b0;

  ili_spi_arbiter #(.DW(DW), .CS_SETUP(CS_SETUP), .CS_GAP(CS_GAP)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_valid_i(req0_valid), .req0_data_i(req0_data), .req0_dc_i(req0_dc),
    .req0_last_i(req0_last), .req0_ready_o(req0_ready),
    .req1_valid_i(req1_valid), .req1_data_i(req1_data), .req1_dc_i(req1_dc),
    .req1_last_i(req1_last), .req1_ready_o(req1_ready),
    .tx_valid_o(tx_valid), .tx_data_o(tx_data), .tx_dc_o(tx_dc),
    .tx_ready_i(tx_ready), .tx_idle_i(tx_idle),
    .cs_o(cs), .grant_o(grant), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Observed trace (sampled at negedge) and log of accepted bytes.
  logic       tr_cs[$], tr_busy[$], tr_txv[$], tr_r0[$], tr_r1[$];
  logic [1:0] tr_grant[$];
  int         log_owner[$];
  logic [7:0] log_data[$];
  logic       log_dc[$];

  // Burst-level model: who owns the bus, how long CS has been low, whether the
  // last byte went out, and how much CS-high gap remains.
  int m_owner, m_since, m_gap, m_fav;
  bit m_drained;

  task automatic m_reset();
    m_owner = -1; m_since = 0; m_gap = 0; m_fav = 0; m_drained = 1'b0;
  endtask

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  initial begin
    logic       v[2], l[2], dcv[2];
    logic [7:0] d[2];
    logic       xfer;
    logic [15:0] e, a;
    logic       e_txv, e_txdc, e_r0, e_r1;
    logic [7:0] e_txd;
    m_reset();
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) m_reset();
      v[0] = req0_valid; v[1] = req1_valid;
      d[0] = req0_data;  d[1] = req1_data;
      dcv[0] = req0_dc;  dcv[1] = req1_dc;
      l[0] = req0_last;  l[1] = req1_last;
      xfer = (m_owner >= 0) && (m_since >= CS_SETUP) && !m_drained;
      e_txv = 1'b0; e_txd = 8'h00; e_txdc = 1'b1; e_r0 = 1'b0; e_r1 = 1'b0;
      if (xfer) begin
        e_txv  = v[m_owner];
        e_txd  = d[m_owner];
        e_txdc = dcv[m_owner];
        e_r0   = (m_owner == 0) && v[0] && tx_ready;
        e_r1   = (m_owner == 1) && v[1] && tx_ready;
      end
      e = {(m_owner < 0), (m_owner == 1), (m_owner == 0), (m_owner >= 0 || m_gap > 0),
           e_txv, e_txd, e_txdc, e_r0, e_r1};
      a = {cs, grant, busy, tx_valid, tx_data, tx_dc, req0_ready, req1_ready};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL cycle%0d {cs,grant,busy,txv,txd,txdc,r0,r1}: got %h, required %h",
                 cyc, a, e);
      end
      tr_cs.push_back(cs); tr_busy.push_back(busy); tr_txv.push_back(tx_valid);
      tr_r0.push_back(req0_ready); tr_r1.push_back(req1_ready); tr_grant.push_back(grant);
      if (tx_valid && tx_ready) begin
        log_owner.push_back(grant == 2'b10 ? 1 : 0);
        log_data.push_back(tx_data);
        log_dc.push_back(tx_dc);
      end
      if (rst_n) begin
        if (m_owner < 0) begin
          if (m_gap > 0) m_gap--;
          else if (v[0] || v[1]) begin
            m_owner   = (v[0] && v[1]) ? m_fav : (v[0] ? 0 : 1);
            m_since   = 0;
            m_drained = 1'b0;
          end
        end else if (m_drained) begin
          if (tx_idle) begin
            m_fav   = 1 - m_owner;
            m_owner = -1;
            m_gap   = CS_GAP;
          end
        end else begin
          if (xfer && v[m_owner] && tx_ready && l[m_owner]) m_drained = 1'b1;
          m_since++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      tx_ready = rdy_alt ? ~tx_ready : 1'b1;
    end
  end

  // Burst descriptions for the two requester drivers.
  logic [7:0] b_data[2][8];
  logic       b_dc[2][8];
  int         b_pause[2][8];
  int         b_n[2];

  task automatic set_req(input int who, input logic v, input logic [7:0] d, input logic dc,
                         input logic l);
    if (who == 0) begin
      req0_valid = v; req0_data = d; req0_dc = dc; req0_last = l;
    end else begin
      req1_valid = v; req1_data = d; req1_dc = dc; req1_last = l;
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive(input int who);
    int i, guard;
    logic acc;
    i = 0; guard = 0;
    while (i < b_n[who] && guard < 200) begin
      if (b_pause[who][i] > 0) begin
        set_req(who, 1'b0, 8'h00, 1'b0, 1'b0);
        step(b_pause[who][i]);
        b_pause[who][i] = 0;
      end
      set_req(who, 1'b1, b_data[who][i], b_dc[who][i], (i == b_n[who] - 1));
      @(negedge clk);
      acc = (who == 0) ? req0_ready : req1_ready;
      @(posedge clk); #1;
      if (acc) i++;
      guard++;
    end
    set_req(who, 1'b0, 8'h00, 1'b0, 1'b0);
    check($sformatf("drive%0d_bytes_sent", who), i, b_n[who]);
  endtask

  task automatic set_burst(input int who, input int n, input logic [7:0] d0,
                           input logic [7:0] d1, input logic [7:0] d2, input logic [2:0] dcs);
    b_n[who] = n;
    b_data[who][0] = d0; b_data[who][1] = d1; b_data[who][2] = d2;
    for (int k = 0; k < 3; k++) b_dc[who][k] = dcs[k];
    for (int k = 0; k < 8; k++) b_pause[who][k] = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  function automatic int find_cs_low(input int s);
    for (int i = s; i < tr_cs.size(); i++) if (!tr_cs[i]) return i;
    return -1;
  endfunction

  function automatic int find_txv(input int s);
    for (int i = s; i < tr_txv.size(); i++) if (tr_txv[i]) return i;
    return -1;
  endfunction

  // CS-high cycles between the first and second CS-low runs after index s.
  function automatic int gap_len(input int s);
    int i, n;
    i = find_cs_low(s);
    if (i < 0) return -1;
    while (i < tr_cs.size() && !tr_cs[i]) i++;
    n = 0;
    while (i < tr_cs.size() && tr_cs[i]) begin n++; i++; end
    return (i < tr_cs.size()) ? n : -1;
  endfunction

  function automatic int cs_low_runs(input int s);
    int n = 0;
    for (int i = s; i < tr_cs.size(); i++)
      if (!tr_cs[i] && (i == s || tr_cs[i-1])) n++;
    return n;
  endfunction

  task automatic check_log(input string name, input int idx, input int owner,
                           input logic [7:0] data, input logic dc);
    if (idx >= log_data.size()) begin
      check({name, "_present"}, log_data.size(), idx + 1);
    end else begin
      check({name, "_owner"}, log_owner[idx], owner);
      check({name, "_data"}, int'(log_data[idx]), int'(data));
      check({name, "_dc"}, int'(log_dc[idx]), int'(dc));
    end
  endtask

  initial begin
    int s, l0, n, k, cnt;
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, l0, n, k, cnt;
    // Test 1: reset state, then one single-byte command burst.
    step(3);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_cs", cs, 1);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_dc", tx_dc, 1);
    check("rst_tx_data", tx_data, 0);
    @(posedge clk); #1;
    s = tr_cs.size(); l0 = log_data.size();
    set_burst(0, 1, 8'h01, 8'h00, 8'h00, 3'b000);
    drive(0);
    step(6);
    check("t1_cs_lead", find_txv(s) - find_cs_low(s), CS_SETUP);
    check("t1_transfers", log_data.size() - l0, 1);
    check_log("t1_b0", l0, 0, 8'h01, 1'b0);
    cnt = 0;
    for (int i = s; i < tr_cs.size(); i++) if (tr_cs[i] && tr_busy[i]) cnt++;
    check("t1_gap_busy_cycles", cnt, 2);
    check("t1_end_busy", busy, 0);

    // Test 2: both request in first IDLE after reset; req0 wins, then req1.
    do_reset();
    s = tr_cs.size(); l0 = log_data.size();
    set_burst(0, 2, 8'h10, 8'h11, 8'h00, 3'b010);
    set_burst(1, 1, 8'h20, 8'h00, 8'h00, 3'b001);
    fork
      drive(0);
      drive(1);
    join
    step(5);
    check_log("t2_b0", l0, 0, 8'h10, 1'b0);
    check_log("t2_b1", l0 + 1, 0, 8'h11, 1'b1);
    check_log("t2_b2", l0 + 2, 1, 8'h20, 1'b1);
    check("t2_cs_high_between", gap_len(s), 3);

    // Test 3: req1 three-byte burst with tx_ready alternating.
    s = tr_cs.size(); l0 = log_data.size();
    set_burst(1, 3, 8'h2C, 8'hAA, 8'h55, 3'b110);
    rdy_alt = 1'b1;
    drive(1);
    rdy_alt = 1'b0;
    step(5);
    check("t3_transfers", log_data.size() - l0, 3);
    check_log("t3_b0", l0, 1, 8'h2C, 1'b0);
    check_log("t3_b1", l0 + 1, 1, 8'hAA, 1'b1);
    check_log("t3_b2", l0 + 2, 1, 8'h55, 1'b1);
    cnt = 0;
    for (int i = s; i < tr_r1.size(); i++) if (tr_r1[i]) cnt++;
    check("t3_req1_ready_cycles", cnt, 3);
    check("t3_cs_low_runs", cs_low_runs(s), 1);

    // Test 4: req0 stalls 4 cycles mid-burst while req1 waits.
    s = tr_cs.size(); l0 = log_data.size();
    set_burst(0, 3, 8'h30, 8'h31, 8'h32, 3'b111);
    b_pause[0][1] = 4;
    set_burst(1, 1, 8'h40, 8'h00, 8'h00, 3'b001);
    fork
      drive(0);
      drive(1);
    join
    step(5);
    check_log("t4_b0", l0, 0, 8'h30, 1'b1);
    check_log("t4_b1", l0 + 1, 0, 8'h31, 1'b1);
    check_log("t4_b2", l0 + 2, 0, 8'h32, 1'b1);
    check_log("t4_b3", l0 + 3, 1, 8'h40, 1'b1);
    cnt = 0;
    for (int i = s; i < tr_r1.size(); i++) if (tr_r1[i] && tr_grant[i] == 2'b01) cnt++;
    check("t4_req1_ready_while_req0", cnt, 0);
    check("t4_cs_low_runs", cs_low_runs(s), 2);
    k = find_cs_low(s); cnt = 0;
    while (k >= 0 && k < tr_cs.size() && !tr_cs[k]) begin
      if (tr_grant[k] != 2'b01) cnt++;
      k++;
    end
    check("t4_grant_changes", cnt, 0);

    // Test 5: last byte accepted while the transmitter is still shifting.
    l0 = log_data.size();
    set_burst(0, 2, 8'h50, 8'h51, 8'h00, 3'b011);
    tx_idle = 1'b0;
    drive(0);
    n = 0;
    repeat (5) begin @(negedge clk); if (!cs) n++; @(posedge clk); #1; end
    tx_idle = 1'b1;
    repeat (10) begin @(negedge clk); if (cs) break; n++; @(posedge clk); #1; end
    check("t5_cs_low_after_last", n, 6);
    check_log("t5_b1", l0 + 1, 0, 8'h51, 1'b1);
    step(5);

    // Test 6: reset mid-burst, then restart with req0 favoured.
    set_req(1, 1'b1, 8'h60, 1'b1, 1'b0);
    k = 0;
    do begin @(negedge clk); k++; end while (!tx_valid && k < 20);
    check("t6_reached_xfer", tx_valid, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("t6_async_cs", cs, 1);
    check("t6_async_grant", grant, 0);
    check("t6_async_tx_valid", tx_valid, 0);
    check("t6_async_busy", busy, 0);
    set_req(1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(2);
    rst_n = 1'b1;
    l0 = log_data.size();
    set_burst(0, 1, 8'h70, 8'h00, 8'h00, 3'b001);
    set_burst(1, 1, 8'h71, 8'h00, 8'h00, 3'b001);
    fork
      drive(0);
      drive(1);
    join
    step(5);
    check_log("t6_b0", l0, 0, 8'h70, 1'b1);
    check_log("t6_b1", l0 + 1, 1, 8'h71, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
